// File: rtl/line_cmd_if.sv
// Producer-side command channel of the line-command queue: valid/ready plus
// the four 8-bit line endpoints.
interface line_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_stax;
    logic [7:0] cmd_stay;
    logic [7:0] cmd_endx;
    logic [7:0] cmd_endy;

    modport master (
        output cmd_valid, cmd_stax, cmd_stay, cmd_endx, cmd_endy,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_stax, cmd_stay, cmd_endx, cmd_endy,
        output cmd_ready
    );
endinterface

// File: rtl/line_cmd_queue.sv
// Line-command FIFO and dispatcher directly upstream of the Bresenham line drawer.
// Define LINE_CMD_STATS_EN to add the lines_done / stall_cnt statistics counters.
module line_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          pclk,
    input  logic          rst_n,
    line_cmd_if.slave     cmd,
    input  logic          flush,
    output logic          go,
    input  logic          busy,
    output logic [7:0]    stax,
    output logic [7:0]    stay,
    output logic [7:0]    endx,
    output logic [7:0]    endy,
    output logic [AW:0]   level,
    output logic          idle
`ifdef LINE_CMD_STATS_EN
    ,
    output logic [15:0]   lines_done,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_GO    = 2'd2,
        ST_DRAW  = 2'd3
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    state_t          state_reg;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wptr_reg;
    logic [AW-1:0]   rptr_reg;
    logic [AW:0]     level_reg;
    logic [31:0]     coord_reg;

    logic            push;
    logic            pop;
    logic            have_cmd;

    assign cmd.cmd_ready = (level_reg != FULL_LEVEL);
    assign have_cmd      = (level_reg != '0);

    // flush wins over both a same-cycle push and a scheduled pop
    assign push = cmd.cmd_valid && cmd.cmd_ready && !flush;
    assign pop  = have_cmd && !flush &&
                  ((state_reg == ST_IDLE) || (state_reg == ST_DRAW && !busy));

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wptr_reg] <= {cmd.cmd_stax, cmd.cmd_stay, cmd.cmd_endx, cmd.cmd_endy};
        end
    end

    // The drawer has no reset and may be mid-line, so reset parks in DRAW
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_DRAW;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
            coord_reg <= '0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + 1'b1;
            end

            if (flush) begin
                rptr_reg  <= wptr_reg;
                level_reg <= '0;
            end else begin
                if (pop) begin
                    rptr_reg <= rptr_reg + 1'b1;
                end
                case ({push, pop})
                    2'b10:   level_reg <= level_reg + 1'b1;
                    2'b01:   level_reg <= level_reg - 1'b1;
                    default: level_reg <= level_reg;
                endcase
            end

            if (pop) begin
                coord_reg <= mem[rptr_reg];
            end

            case (state_reg)
                ST_IDLE:  if (pop) state_reg <= ST_SETUP;
                ST_SETUP: state_reg <= ST_GO;
                ST_GO:    state_reg <= ST_DRAW;
                ST_DRAW:  if (!busy) state_reg <= pop ? ST_SETUP : ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign go    = (state_reg == ST_GO);
    assign stax  = coord_reg[31:24];
    assign stay  = coord_reg[23:16];
    assign endx  = coord_reg[15:8];
    assign endy  = coord_reg[7:0];
    assign level = level_reg;
    assign idle  = (state_reg == ST_IDLE) && !have_cmd && !busy;

`ifdef LINE_CMD_STATS_EN
    logic        drew_reg;
    logic [15:0] lines_reg;
    logic [15:0] stall_reg;

    // drew_reg separates a real line from the post-reset DRAW wait
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            drew_reg  <= 1'b0;
            lines_reg <= '0;
            stall_reg <= '0;
        end else begin
            if (state_reg == ST_GO) begin
                drew_reg <= 1'b1;
            end else if (state_reg == ST_DRAW && !busy) begin
                drew_reg <= 1'b0;
            end

            if (flush) begin
                lines_reg <= '0;
                stall_reg <= '0;
            end else begin
                if (state_reg == ST_DRAW && !busy && drew_reg && lines_reg != 16'hFFFF) begin
                    lines_reg <= lines_reg + 1'b1;
                end
                if (cmd.cmd_valid && !cmd.cmd_ready && stall_reg != 16'hFFFF) begin
                    stall_reg <= stall_reg + 1'b1;
                end
            end
        end
    end

    assign lines_done = lines_reg;
    assign stall_cnt  = stall_reg;
`endif

endmodule
